commit_fence_sequencer: RTL and testbench
=========================================

// Module: commit_fence_sequencer
// PURPOSE
//  Sequences fence-class instructions retiring on commit port 0: FENCE, FENCE.I, SFENCE.VMA, FENCE.T.
//  Order: drain store buffer, flush D$, invalidate I$/TLB, then pulse done + pipeline flush.
//  Sits beside the commit stage; commit stage holds the instruction until done_o.
//  Replaces the ad-hoc no_st_pending gating with an explicit, timed, single-owner FSM.
// PARAMETERS
//  TIMEOUT_CYCLES  default 1024  watchdog limit for the DRAIN and FLUSH_D states; 0 disables the watchdog
//  CNT_W           default 11    counter width; must satisfy 2**CNT_W > TIMEOUT_CYCLES
// PORTS
//  clk_i              in   1  clock
//  rst_ni             in   1  async active-low reset
//  halt_i             in   1  core halt request; blocks new acceptance only
//  req_valid_i        in   1  fence-class instr valid at commit port 0, no exception
//  req_op_i           in   2  00 FENCE, 01 FENCE_I, 10 SFENCE_VMA, 11 FENCE_T
//  req_ready_o        out  1  request accepted this cycle when high together with req_valid_i
//  no_st_pending_i    in   1  LSU store buffer empty
//  dcache_flush_o     out  1  D$ flush request (level)
//  dcache_flush_ack_i in   1  D$ flush complete (1-cycle pulse)
//  icache_flush_o     out  1  I$ invalidate (1-cycle pulse)
//  tlb_flush_o        out  1  TLB flush (1-cycle pulse)
//  done_o             out  1  commit ack for the fence (1-cycle pulse)
//  flush_pipeline_o   out  1  pipeline flush request (1-cycle pulse, same cycle as done_o)
//  busy_o             out  1  FSM not in IDLE
//  timeout_o          out  1  sticky watchdog flag; cleared on next acceptance
// BEHAVIOUR
//  Reset: state=IDLE, op=0, cnt=0; every output 0.
//  Outputs are decoded from registered state; none is driven combinationally from req_valid_i.
//  req_ready_o = (state==IDLE) & !halt_i.
//  Accept (req_valid_i & req_ready_o): latch op, clear cnt and timeout_o, go to DRAIN.
//  IDLE: req_valid_i is ignored while not ready. Acceptance adds no wait cycle.
//  DRAIN: wait for no_st_pending_i; op-dependent next state:
//   FENCE, FENCE_I, FENCE_T -> FLUSH_D; SFENCE_VMA -> INV_TLB.
//  FLUSH_D: dcache_flush_o=1 while in state. On dcache_flush_ack_i the next state is:
//   FENCE -> DONE; FENCE_I, FENCE_T -> INV_I.
//  INV_I: icache_flush_o=1 for 1 cycle. Next: FENCE_T -> INV_TLB; FENCE_I -> DONE.
//  INV_TLB: tlb_flush_o=1 for 1 cycle, then DONE.
//  DONE: done_o=1 and flush_pipeline_o=1 for 1 cycle, then IDLE.
//  Min latency, accept cycle = T:
//   FENCE done at T+3; FENCE_I at T+4; SFENCE_VMA at T+3; FENCE_T at T+5.
//   Each extra DRAIN or FLUSH_D wait cycle adds 1 cycle.
//  Watchdog (TIMEOUT_CYCLES>0): cnt increments each cycle in DRAIN or FLUSH_D.
//   cnt clears on every state change.
//   When cnt reaches TIMEOUT_CYCLES-1, set timeout_o=1 and saturate cnt.
//   The FSM keeps waiting; there is no abort.
//  dcache_flush_ack_i outside FLUSH_D: ignored; it is never remembered for later.
//  halt_i mid-sequence: ignored; the sequence completes. Only IDLE acceptance is blocked.
//  Back-to-back: a new request can be accepted in the cycle after DONE (IDLE).
//  Reset mid-sequence: immediate return to IDLE with all outputs 0. No done_o is emitted.
//  Illegal state encoding: recover to IDLE.
// TESTING
//  1 FENCE, no_st_pending=1, ack in first FLUSH_D cycle:
//    -> dcache_flush_o at T+2 only; done_o=flush_pipeline_o=1 at T+3.
//  2 FENCE_I, no_st_pending low for 5 cycles, ack 4 cycles after FLUSH_D entry:
//    -> icache_flush_o 1 pulse, then done_o; total latency 13.
//  3 SFENCE_VMA: dcache_flush_o never asserted; tlb_flush_o at T+2; done_o at T+3.
//  4 FENCE_T: D$ flush, then icache_flush_o, then tlb_flush_o, then done_o, in strict order.
//    Each pulse is exactly 1 cycle.
//  5 TIMEOUT_CYCLES=8, no_st_pending held 0:
//    timeout_o=1 after 8 DRAIN cycles and stays high.
//    Release -> normal completion; next accept clears timeout_o.
//  6 Boundary cases:
//    halt_i=1 in IDLE -> req_ready_o=0, no accept.
//    Stray ack in DRAIN -> ignored; FLUSH_D still waits for a fresh ack.
//    rst_ni low in FLUSH_D -> all outputs 0 asynchronously, busy_o=0.

Source files
------------

// File: rtl/commit_fence_sequencer_if.sv
// Commit-port-0 fence request bundle plus cache/TLB control
// and completion signals for the fence sequencer.
interface commit_fence_sequencer_if;
  logic       halt_i;
  logic       req_valid_i;
  logic [1:0] req_op_i;
  logic       req_ready_o;
  logic       no_st_pending_i;
  logic       dcache_flush_o;
  logic       dcache_flush_ack_i;
  logic       icache_flush_o;
  logic       tlb_flush_o;
  logic       done_o;
  logic       flush_pipeline_o;
  logic       busy_o;
  logic       timeout_o;

  modport master (
    output halt_i, req_valid_i, req_op_i,
    output no_st_pending_i, dcache_flush_ack_i,
    input  req_ready_o, dcache_flush_o,
    input  icache_flush_o, tlb_flush_o,
    input  done_o, flush_pipeline_o,
    input  busy_o, timeout_o
  );

  modport slave (
    input  halt_i, req_valid_i, req_op_i,
    input  no_st_pending_i, dcache_flush_ack_i,
    output req_ready_o, dcache_flush_o,
    output icache_flush_o, tlb_flush_o,
    output done_o, flush_pipeline_o,
    output busy_o, timeout_o
  );
endinterface

// File: rtl/commit_fence_sequencer.sv
// Fence-class commit sequencer: drain stores, flush D$,
// invalidate I$/TLB, then ack commit and flush the pipeline.
module commit_fence_sequencer #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  commit_fence_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, DRAIN, FLUSH_D, INV_I, INV_TLB, DONE
  } state_e;

  typedef enum logic [1:0] {
    OP_FENCE, OP_FENCE_I, OP_SFENCE_VMA, OP_FENCE_T
  } op_e;

  localparam bit WD_EN = TIMEOUT_CYCLES > 0;
  localparam logic [CNT_W-1:0] CNT_LIM =
    CNT_W'(WD_EN ? TIMEOUT_CYCLES - 1 : 0);

  state_e           state;
  state_e           nxt;
  op_e              op;
  logic [CNT_W-1:0] cnt;
  logic             timeout_q;
  logic             ready;
  logic             accept;
  logic             waiting;

  // Gated by reset so every output reads 0 while held in reset
  assign ready   = (state == IDLE) & ~bus.halt_i & rst_ni;
  assign accept  = bus.req_valid_i & ready;
  assign waiting = (state == DRAIN) | (state == FLUSH_D);

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (accept) nxt = DRAIN;
      DRAIN:
        if (bus.no_st_pending_i)
          nxt = (op == OP_SFENCE_VMA) ? INV_TLB : FLUSH_D;
      FLUSH_D:
        if (bus.dcache_flush_ack_i)
          nxt = (op == OP_FENCE_I || op == OP_FENCE_T)
              ? INV_I : DONE;
      INV_I:   nxt = (op == OP_FENCE_T) ? INV_TLB : DONE;
      INV_TLB: nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      op        <= OP_FENCE;
      cnt       <= '0;
      timeout_q <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) begin
        op        <= op_e'(bus.req_op_i);
        cnt       <= '0;
        timeout_q <= 1'b0;
      end else if (waiting && WD_EN) begin
        if (cnt == CNT_LIM) timeout_q <= 1'b1;
        if (nxt != state)
          cnt <= '0;
        else if (cnt != CNT_LIM)
          cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
    end
  end

  assign bus.req_ready_o      = ready;
  assign bus.dcache_flush_o   = state == FLUSH_D;
  assign bus.icache_flush_o   = state == INV_I;
  assign bus.tlb_flush_o      = state == INV_TLB;
  assign bus.done_o           = state == DONE;
  assign bus.flush_pipeline_o = state == DONE;
  assign bus.busy_o           = state != IDLE;
  assign bus.timeout_o        = timeout_q;

endmodule

// File: tb/tb_commit_fence_sequencer.sv
// Directed bench for commit_fence_sequencer; expected per-cycle
// output vectors are queued from a small model, then popped.
module tb_commit_fence_sequencer;

  localparam int TO = 8;
  localparam logic [1:0] F  = 2'b00;
  localparam logic [1:0] FI = 2'b01;
  localparam logic [1:0] SF = 2'b10;
  localparam logic [1:0] FT = 2'b11;

  typedef struct {
    string      tag;
    logic [7:0] v;
  } exp_t;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  int   npass = 0;
  int   ntot = 0;
  logic to_flag = 1'b0;
  exp_t sb[$];

  commit_fence_sequencer_if bus ();

  commit_fence_sequencer #(
    .TIMEOUT_CYCLES(TO),
    .CNT_W(4)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ev(
    logic r, logic df, logic ic, logic tl,
    logic dn, logic b, logic t);
    return {r, df, ic, tl, dn, dn, b, t};
  endfunction

  function automatic logic [7:0] obs();
    return {bus.req_ready_o, bus.dcache_flush_o,
            bus.icache_flush_o, bus.tlb_flush_o,
            bus.done_o, bus.flush_pipeline_o,
            bus.busy_o, bus.timeout_o};
  endfunction

  task automatic chk(string tag, logic [7:0] e);
    logic [7:0] o;
    o = obs();
    ntot++;
    assert (o === e) npass++;
    else $error("FAIL %s got=%b want=%b (rdy,df,ic,tlb,dn,fp,bsy,to)",
                tag, o, e);
  endtask

  task automatic push(string tag, logic [7:0] v);
    exp_t x;
    x.tag = tag;
    x.v   = v;
    sb.push_back(x);
  endtask

  // One clock cycle: drive inputs, check against queue head, advance
  task automatic cyc(logic vld, logic [1:0] op, logic h,
                     logic nsp, logic ack);
    exp_t x;
    bus.req_valid_i        = vld;
    bus.req_op_i           = op;
    bus.halt_i             = h;
    bus.no_st_pending_i    = nsp;
    bus.dcache_flush_ack_i = ack;
    #1;
    if (sb.size() == 0) begin
      ntot++;
      $error("FAIL sb_empty got=%b want=queued entry", obs());
    end else begin
      x = sb.pop_front();
      chk(x.tag, x.v);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(string tag, logic vld, logic h);
    push(tag, ev(!h, 0, 0, 0, 0, 0, to_flag));
    cyc(vld, F, h, 1'b1, 1'b0);
  endtask

  // Model of one full fence sequence; dw/fw are extra wait cycles
  task automatic fence(string tag, logic [1:0] op, int dw, int fw,
                       logic stray, logic h);
    int rest;
    push({tag, "_acc"}, ev(1, 0, 0, 0, 0, 0, to_flag));
    to_flag = 1'b0;
    for (int i = 0; i <= dw; i++) begin
      push({tag, "_drain"}, ev(0, 0, 0, 0, 0, 1, to_flag));
      if (i == TO - 1) to_flag = 1'b1;
    end
    if (op != SF)
      for (int i = 0; i <= fw; i++) begin
        push({tag, "_flushd"}, ev(0, 1, 0, 0, 0, 1, to_flag));
        if (i == TO - 1) to_flag = 1'b1;
      end
    if (op == FI || op == FT)
      push({tag, "_inv_i"}, ev(0, 0, 1, 0, 0, 1, to_flag));
    if (op == SF || op == FT)
      push({tag, "_tlb"}, ev(0, 0, 0, 1, 0, 1, to_flag));
    push({tag, "_done"}, ev(0, 0, 0, 0, 1, 1, to_flag));

    cyc(1'b1, op, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < dw; i++) cyc(1'b0, F, h, 1'b0, stray);
    cyc(1'b0, F, h, 1'b1, 1'b0);
    if (op != SF) begin
      for (int i = 0; i < fw; i++) cyc(1'b0, F, h, 1'b1, 1'b0);
      cyc(1'b0, F, h, 1'b1, 1'b1);
    end
    rest = 1 + ((op == FI || op == FT) ? 1 : 0)
             + ((op == SF || op == FT) ? 1 : 0);
    for (int i = 0; i < rest; i++) cyc(1'b0, F, h, 1'b1, 1'b0);
  endtask

  initial begin
    bus.req_valid_i        = 1'b0;
    bus.req_op_i           = F;
    bus.halt_i             = 1'b0;
    bus.no_st_pending_i    = 1'b0;
    bus.dcache_flush_ack_i = 1'b0;
    #1;
    chk("reset", 8'h00);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;

    idle("idle0", 1'b0, 1'b0);
    fence("fence", F, 0, 0, 1'b0, 1'b0);
    fence("fence_i", FI, 5, 4, 1'b0, 1'b0);
    fence("sfence", SF, 0, 0, 1'b0, 1'b0);
    fence("fence_t", FT, 0, 0, 1'b0, 1'b0);
    idle("idle1", 1'b0, 1'b0);

    fence("to_drain", F, 10, 0, 1'b0, 1'b0);
    idle("to_sticky", 1'b0, 1'b0);
    fence("to_clear", FT, 0, 0, 1'b0, 1'b0);
    fence("to_flushd", F, 0, 9, 1'b0, 1'b0);
    idle("to_sticky2", 1'b0, 1'b0);

    idle("halt_idle", 1'b1, 1'b1);
    idle("halt_idle2", 1'b1, 1'b1);
    idle("halt_rel", 1'b0, 1'b0);
    fence("stray_halt", FI, 2, 3, 1'b1, 1'b1);
    fence("sf_stray", SF, 3, 0, 1'b1, 1'b0);
    idle("idle2", 1'b0, 1'b0);

    push("rst_acc", ev(1, 0, 0, 0, 0, 0, to_flag));
    to_flag = 1'b0;
    push("rst_drain", ev(0, 0, 0, 0, 0, 1, 0));
    cyc(1'b1, F, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, F, 1'b0, 1'b1, 1'b0);
    bus.dcache_flush_ack_i = 1'b0;
    #1;
    chk("rst_flushd", ev(0, 1, 0, 0, 0, 1, 0));
    rst_ni = 1'b0;
    #1;
    chk("rst_async", 8'h00);
    @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    idle("rst_after", 1'b0, 1'b0);
    idle("rst_nodone", 1'b0, 1'b0);
    fence("post_rst", FT, 1, 1, 1'b0, 1'b0);

    ntot++;
    assert (sb.size() == 0) npass++;
    else $error("FAIL sb_drain got=%0d want=0 entries", sb.size());

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
